// File: rtl/pcap_dma_sched.sv
// pcap_dma_sched: sequences position-capture DMA bursts from the sample FIFO
// into host buffers taken from a software-filled address table, and raises
// the capture interrupt with {sample_count, flags} when a buffer ends.
module pcap_dma_sched #(
  parameter int BURST_LEN = 16,
  parameter int TBL_AW    = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              pcap_done_i,
  input  logic [31:0]       addr_i,
  input  logic              addr_wstb_i,
  input  logic [23:0]       blocksize_i,
  input  logic [31:0]       timeout_i,
  input  logic [10:0]       fifo_count_i,
  output logic              dma_req_o,
  output logic [31:0]       dma_addr_o,
  output logic [7:0]        dma_len_o,
  input  logic              dma_ack_i,
  input  logic              dma_done_i,
  input  logic              dma_err_i,
  output logic              irq_o,
  output logic [31:0]       irq_status_o,
  output logic [TBL_AW:0]   tbl_count_o,
  output logic              active_o
);

  localparam int             DEPTH = 1 << TBL_AW;
  localparam logic [7:0]     BLEN  = 8'(BURST_LEN);
  localparam logic [7:0]     F_COMPLETED = 8'h01;
  localparam logic [7:0]     F_BLOCK_FULL = 8'h02;
  localparam logic [7:0]     F_TIMEOUT = 8'h04;
  localparam logic [7:0]     F_DMA_ERR = 8'h08;
  localparam logic [7:0]     F_UNDERRUN = 8'h10;
  localparam logic [7:0]     F_DISARMED = 8'h20;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_DATA, REQ, XFER, IRQ} state_t;

  state_t             state;
  logic [31:0]        mem [DEPTH];
  logic [TBL_AW-1:0]  wr_ptr;
  logic [TBL_AW-1:0]  rd_ptr;
  logic [TBL_AW:0]    count;
  logic               push;
  logic               pop;

  logic [31:0]        cur_addr;
  logic [23:0]        words_left;
  logic [23:0]        sample_count;
  logic [31:0]        timer;
  logic               advance;

  logic [7:0]         want_len;
  logic [7:0]         part_len;
  logic [23:0]        left_after;
  logic [23:0]        count_after;

  // A full table drops pushes; a pop only happens from LOAD with data present.
  assign push        = addr_wstb_i && (count != (TBL_AW+1)'(DEPTH));
  assign pop         = (state == LOAD) && (count != '0);
  assign tbl_count_o = count;
  assign active_o    = (state != IDLE);

  // Burst sizing: cap by burst limit and remaining block space, then by FIFO fill.
  always_comb begin
    want_len    = (words_left < 24'(BURST_LEN)) ? words_left[7:0] : BLEN;
    part_len    = (fifo_count_i < {3'b000, want_len}) ? fifo_count_i[7:0] : want_len;
    left_after  = words_left - {16'h0000, dma_len_o};
    count_after = sample_count + {16'h0000, dma_len_o};
  end

  // Address table storage; no reset so it maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= addr_i;
  end

  // Table pointers and occupancy; push and pop may occur together.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (TBL_AW+1)'(push) - (TBL_AW+1)'(pop);
    end
  end

  // Main sequencer with registered DMA and interrupt outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= IDLE;
      cur_addr     <= '0;
      words_left   <= '0;
      sample_count <= '0;
      timer        <= '0;
      advance      <= 1'b0;
      dma_req_o    <= 1'b0;
      dma_addr_o   <= '0;
      dma_len_o    <= '0;
      irq_o        <= 1'b0;
      irq_status_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_i) state <= LOAD;
        end
        LOAD: begin
          if (count == '0) begin
            irq_o        <= 1'b1;
            irq_status_o <= {24'h000000, F_UNDERRUN};
            advance      <= 1'b0;
            state        <= IRQ;
          end else begin
            cur_addr     <= mem[rd_ptr];
            words_left   <= blocksize_i;
            sample_count <= '0;
            timer        <= '0;
            state        <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (timer != '1) timer <= timer + 1'b1;
          if (!enable_i) begin
            irq_o        <= 1'b1;
            irq_status_o <= {sample_count, F_DISARMED};
            advance      <= 1'b0;
            state        <= IRQ;
          end else if (fifo_count_i >= {3'b000, want_len}) begin
            dma_req_o  <= 1'b1;
            dma_addr_o <= cur_addr;
            dma_len_o  <= want_len;
            timer      <= '0;
            state      <= REQ;
          end else if (pcap_done_i && (fifo_count_i != '0)) begin
            dma_req_o  <= 1'b1;
            dma_addr_o <= cur_addr;
            dma_len_o  <= part_len;
            timer      <= '0;
            state      <= REQ;
          end else if (pcap_done_i) begin
            irq_o        <= 1'b1;
            irq_status_o <= {sample_count, F_COMPLETED};
            advance      <= 1'b0;
            state        <= IRQ;
          end else if ((timeout_i != '0) && (timer >= timeout_i) && (sample_count != '0)) begin
            irq_o        <= 1'b1;
            irq_status_o <= {sample_count, F_TIMEOUT};
            advance      <= 1'b1;
            state        <= IRQ;
          end
        end
        REQ: begin
          // The request stays up until accepted, even if disarmed meanwhile.
          if (dma_ack_i) begin
            dma_req_o <= 1'b0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (dma_done_i) begin
            if (dma_err_i) begin
              irq_o        <= 1'b1;
              irq_status_o <= {sample_count, F_DMA_ERR};
              advance      <= 1'b0;
              state        <= IRQ;
            end else begin
              cur_addr     <= cur_addr + {22'h000000, dma_len_o, 2'b00};
              words_left   <= left_after;
              sample_count <= count_after;
              if (left_after == '0) begin
                irq_o        <= 1'b1;
                irq_status_o <= {count_after, F_BLOCK_FULL};
                advance      <= 1'b1;
                state        <= IRQ;
              end else begin
                state <= WAIT_DATA;
              end
            end
          end
        end
        IRQ: begin
          irq_o <= 1'b0;
          state <= advance ? LOAD : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pcap_dma_sched.md
# pcap_dma_sched

Sequencing controller for the position-capture DMA path. It holds a table of host buffer addresses written by software, decides when enough captured words sit in the sample FIFO to issue an AXI HP0 write burst, and advances through buffers as they fill. It raises the capture interrupt with a status word (flags plus sample count) when a buffer fills, times out, completes, errors, disarms or runs out of addresses. It sits between the PCAP sample FIFO / register block and the AXI HP0 write master.

## Interface
- BURST_LEN, 16: maximum words per DMA burst (1..255).
- TBL_AW, 5: address table depth 2**TBL_AW (32 entries).
- clk_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  capture armed (level).
- pcap_done_i  in  1  level, capture finished (no more samples will enter the FIFO).
- addr_i  in  32  next buffer byte address, 32-bit word aligned.
- addr_wstb_i  in  1  pushes addr_i into the table; ignored when the table is full.
- blocksize_i  in  24  buffer size in words (nonzero), sampled per buffer.
- timeout_i  in  32  idle-flush timeout in clocks; 0 disables.
- fifo_count_i  in  11  words currently in the sample FIFO.
- dma_req_o  out  1  burst request.
- dma_addr_o  out  32  burst byte address.
- dma_len_o  out  8  burst length in words.
- dma_ack_i  in  1  burst accepted.
- dma_done_i  in  1  burst finished, one-cycle pulse.
- dma_err_i  in  1  qualified with dma_done_i; the burst failed.
- irq_o  out  1  one-cycle interrupt pulse.
- irq_status_o  out  32  {sample_count[23:0], flags[7:0]}, latched on irq_o.
- tbl_count_o  out  TBL_AW+1  entries in the table.
- active_o  out  1  high in every state except IDLE.

## Operation
- Flags: bit0 COMPLETED, bit1 BLOCK_FULL, bit2 TIMEOUT, bit3 DMA_ERR, bit4 ADDR_UNDERRUN, bit5 DISARMED, bits 7:6 zero.
- Reset: all outputs 0, table empty, FSM in IDLE.
- States: IDLE, LOAD, WAIT_DATA, REQ, XFER, IRQ.
- IDLE: when enable_i=1, go to LOAD.
- LOAD:
  - Table empty: set UNDERRUN, go to IRQ, then IDLE.
  - Otherwise: pop the head into cur_addr, set words_left = blocksize_i, sample_count = 0, timer = 0, go to WAIT_DATA.
- WAIT_DATA, evaluated in priority order:
  1. enable_i=0: set DISARMED, go to IRQ (final).
  2. fifo_count_i ≥ min(BURST_LEN, words_left): go to REQ with len = min(BURST_LEN, words_left).
  3. pcap_done_i=1 and fifo_count_i > 0: go to REQ with len = min(fifo_count_i, BURST_LEN, words_left).
  4. pcap_done_i=1 and fifo_count_i = 0: set COMPLETED, go to IRQ (final).
  5. timeout_i ≠ 0, timer ≥ timeout_i and sample_count > 0: set TIMEOUT, go to IRQ (advance to the next buffer).
  - timer increments every WAIT_DATA cycle and clears on every REQ entry.
- REQ:
  - dma_req_o=1; dma_addr_o and dma_len_o are held stable until dma_ack_i.
  - On ack: deassert the next cycle, go to XFER.
  - enable_i falling does not withdraw an issued request.
- XFER, on dma_done_i:
  - dma_err_i=1: set DMA_ERR, go to IRQ (final).
  - Otherwise: cur_addr += 4·len, words_left −= len, sample_count += len.
  - If words_left becomes 0: set BLOCK_FULL and go to IRQ (advance).
  - Else return to WAIT_DATA.
- IRQ:
  - irq_o=1 for one cycle; irq_status_o latches the flags and sample_count.
  - Flags then clear.
  - Final: go to IDLE.
  - Advance: go to LOAD.
- A FIFO that empties exactly as the block fills reports BLOCK_FULL only. The next LOAD then WAIT_DATA reports COMPLETED with sample_count 0.
- Table:
  - Push and pop in the same cycle are both honoured.
  - A push when full is dropped and the count is unchanged.
  - The table survives IDLE; only reset_i clears it.

## Timing
- enable_i high in IDLE → LOAD next cycle → WAIT_DATA the cycle after. Earliest dma_req_o is 3 cycles after enable_i.
- dma_req_o falls the cycle after dma_ack_i is sampled high.
- irq_o is asserted 1 cycle after the deciding dma_done_i or condition.
- The next dma_req_o after a BLOCK_FULL irq is no earlier than 3 cycles after irq_o (IRQ→LOAD→WAIT_DATA→REQ).
- reset_i mid-burst forces IDLE immediately and drops dma_req_o. The DMA master must be reset alongside.
- Arithmetic:
  - cur_addr wraps modulo 2^32.
  - sample_count is 24-bit and cannot exceed blocksize_i.
  - timer saturates at 2^32−1.

## Test plan
- Full buffer: push 2 addresses (0x1000, 0x2000), blocksize 32, BURST_LEN 16, FIFO count 64 → bursts at 0x1000/16, 0x1040/16, then irq status 0x00002002. Continue into 0x2000.
- Partial completion: blocksize 64, FIFO 20 then pcap_done_i with 4 left → bursts of 16 and 4, then irq status 0x00001401.
- Timeout: timeout_i 100, 16 words then FIFO stalls at 3 → irq TIMEOUT (0x00001004) ~101 cycles after the first done. The next buffer is loaded.
- Underrun and overflow: enable with empty table → irq 0x00000010, return to IDLE. Push 33 addresses → tbl_count_o = 32.
- DMA error plus disarm: dma_err_i on the first done → irq 0x00000008 with sample_count 0. Separately, drop enable_i in WAIT_DATA → irq 0x20 (DISARMED, sample_count in bits 31:8), active_o falls.
- Async reset asserted during REQ → dma_req_o, irq_o and active_o are 0 within the same cycle, and tbl_count_o is 0.
